// File: rtl/fir_pkg.sv
// fir_pkg -- shared constants for the 8-tap FIR filter.
// Contents: tap count, coefficient width and values, output scaling shift,
// rounding constant and accumulator width.
`timescale 1ns/1ps
package fir_pkg;

  localparam int NTAPS       = 8;
  localparam int COEF_W      = 6;
  localparam int COEF_SHIFT  = 7;
  localparam int ROUND_CONST = 64;
  localparam int ACC_W       = 40;

  // Coefficients c[0..7]. The leftmost element of the concatenation is
  // index NTAPS-1. The set is symmetric, and its sum is 128, which gives unity DC gain
  // after the shift by COEF_SHIFT.
  localparam logic [NTAPS-1:0][COEF_W-1:0] COEFS = {
    6'd1, 6'd6, 6'd18, 6'd39, 6'd39, 6'd18, 6'd6, 6'd1
  };

endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line -- NTAPS-1 stage sample delay line for the FIR filter.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset, clears every stage
//   din_i  : current input sample, x[0]
//   taps_o : previous samples, taps_o[k-1] = x[k] for k = 1..NTAPS-1
`timescale 1ns/1ps
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_W-1:0]               din_i,
  output logic [NTAPS-2:0][DATA_W-1:0]    taps_o
);

  logic [NTAPS-2:0][DATA_W-1:0] taps_q;
  logic [NTAPS-2:0][DATA_W-1:0] taps_d;

  // Shift toward higher indices. The oldest sample drops off the top.
  always_comb begin
    taps_d = {taps_q[NTAPS-3:0], din_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/fir.sv
// fir -- 8-tap direct-form FIR filter with fixed unsigned coefficients.
// The filter has no handshake. One sample enters on every rising edge, and the result is
// registered, so the latency is one edge.
// Ports:
//   clk      : rising-edge clock
//   Reset    : asynchronous active-high reset, clears the output and history
//   Data_in  : unsigned input sample, DATA_W bits
//   Data_out : unsigned filtered sample, DATA_W bits, registered
// Build option: define FIR_ROUND_EN to round half-up when scaling.
// Without FIR_ROUND_EN, the scaled result is truncated.
`timescale 1ns/1ps
module fir
  import fir_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] Data_out
);

  logic [NTAPS-2:0][DATA_W-1:0] taps;
  logic [ACC_W-1:0]             acc;
  logic [DATA_W-1:0]            data_out_d;
  logic [DATA_W-1:0]            data_out_q;

  // Scales the accumulator back to sample range.
  // With a 32-bit input, the accumulator peaks below 2^39. The optional +64 therefore
  // cannot carry out of ACC_W bits.
  function automatic logic [DATA_W-1:0] scale_out(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] t;
`ifdef FIR_ROUND_EN
    t = (a + ACC_W'(ROUND_CONST)) >> COEF_SHIFT;
`else
    t = a >> COEF_SHIFT;
`endif
    return DATA_W'(t);
  endfunction

  fir_delay_line #(
    .DATA_W (DATA_W)
  ) u_delay (
    .clk    (clk),
    .rst    (Reset),
    .din_i  (Data_in),
    .taps_o (taps)
  );

  // Multiply-accumulate over the current sample and the delay line
  always_comb begin
    acc = ACC_W'(COEFS[0]) * ACC_W'(Data_in);
    for (int k = 1; k < NTAPS; k++) begin
      acc = acc + ACC_W'(COEFS[k]) * ACC_W'(taps[k-1]);
    end
    data_out_d = scale_out(acc);
  end

  // Output register
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign Data_out = data_out_q;

endmodule

// File: tb/tb_fir.sv
`timescale 1ns/1ps
module tb_fir;

  logic        clk;
  logic        Reset;
  logic [31:0] Data_in;
  logic [31:0] Data_out;

  int tests = 0;
  int fails = 0;

  fir #(.DATA_W(32)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .Data_in  (Data_in),
    .Data_out (Data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference model state
  int          C [8] = '{1, 6, 18, 39, 39, 18, 6, 1};
  logic [31:0] hist [7];
  logic [31:0] sb_q [$];

  typedef struct {
    string       name;
    bit          rst_before;
    logic [31:0] din;
    logic [31:0] exp;
    bit          chk;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input string n, input bit r, input logic [31:0] d,
                              input logic [31:0] e, input bit c);
    vec_t v;
    v.name = n; v.rst_before = r; v.din = d; v.exp = e; v.chk = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 7; k++) hist[k] = '0;
  endtask

  task automatic model_step(input logic [31:0] din, output logic [31:0] y);
    logic [63:0] a;
    a = 64'(din) * 64'(C[0]);
    for (int k = 1; k < 8; k++) a = a + 64'(hist[k-1]) * 64'(C[k]);
`ifdef FIR_ROUND_EN
    a = a + 64'd64;
`endif
    a = a >> 7;
    y = a[31:0];
    for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = din;
  endtask

  // This task is called at edge+1. It drives the sample and queues the expected output.
  // It then waits one edge and compares the DUT output against the expected value.
  task automatic step(input logic [31:0] din, input logic [31:0] exp_tab, input bit use_tab,
                      input string name, output logic [31:0] act, output logic [31:0] expv);
    logic [31:0] m;
    Data_in = din;
    model_step(din, m);
    sb_q.push_back(use_tab ? exp_tab : m);
    @(posedge clk);
    #1;
    act  = Data_out;
    expv = sb_q.pop_front();
    check(name, act, expv);
  endtask

  // This task is called at edge+1. It produces a 5 ns reset pulse between edges.
  task automatic reset_pulse(input string name);
    Reset = 1'b1;
    model_clear();
    #1;
    check(name, Data_out, 32'd0);
    #4;
    Reset = 1'b0;
  endtask

  logic [31:0] act, expv, hold;
  int          err_sum;

  initial begin
    logic [31:0] imp128 [9] = '{1, 6, 18, 39, 39, 18, 6, 1, 0};
    logic [31:0] step1k [10] = '{7, 54, 195, 500, 804, 945, 992, 1000, 1000, 1000};
`ifdef FIR_ROUND_EN
    logic [31:0] imp100 [9] = '{1, 5, 14, 30, 30, 14, 5, 1, 0};
`else
    logic [31:0] imp100 [9] = '{0, 4, 14, 30, 30, 14, 4, 0, 0};
`endif

    for (int i = 0; i < 9; i++)
      vecs.push_back(mk("impulse128", i == 0, (i == 0) ? 32'd128 : 32'd0, imp128[i], 1'b1));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk("step1000", i == 0, 32'd1000, step1k[i], 1'b1));
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk("impulse100", i == 0, (i == 0) ? 32'd100 : 32'd0, imp100[i], 1'b1));
    for (int i = 0; i < 11; i++)
      vecs.push_back(mk("fullscale", i == 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, i >= 7));

    // Hold reset across several edges with non-zero input
    Reset   = 1'b1;
    Data_in = 32'hDEAD_BEEF;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", Data_out, 32'd0);
    #4;
    Reset = 1'b0;

    // Edge 1 after release: only c[0] contributes
    step(32'd12800, 32'd100, 1'b1, "first_edge", act, expv);

    // Table-driven vectors
    foreach (vecs[i]) begin
      if (vecs[i].rst_before) reset_pulse({vecs[i].name, "_rst"});
      step(vecs[i].din, vecs[i].exp, vecs[i].chk, vecs[i].name, act, expv);
    end

    // Mid-stream reset: Data_out clears at once, then re-ramps from 7
    reset_pulse("midrst_pre");
    for (int i = 0; i < 9; i++) step(32'd1000, step1k[i], 1'b1, "midrst_ramp", act, expv);
    reset_pulse("midrst_async_clear");
    step(32'd1000, 32'd7, 1'b1, "midrst_reramp0", act, expv);
    step(32'd1000, 32'd54, 1'b1, "midrst_reramp1", act, expv);

    // Output stays stable while the input changes between edges
    hold = expv;
    Data_in = 32'h1234_5678;
    #3;
    check("stable_between_edges", Data_out, hold);
    Data_in = 32'd1000;
    @(posedge clk);
    #1;
    check("after_glitch", Data_out, 32'd195);
    hist[6] = hist[5]; hist[5] = hist[4]; hist[4] = hist[3]; hist[3] = hist[2];
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = 32'd1000;

    // Random stream against the reference model
    reset_pulse("random_rst");
    err_sum = 0;
    for (int i = 0; i < 1000; i++) begin
      step($urandom(), 32'd0, 1'b0, "random", act, expv);
      if (act !== expv) err_sum++;
    end
    tests++;
    if (err_sum != 0) begin
      fails++;
      $display("FAIL random_mean_err: got %0d mismatching outputs, expected 0", err_sum);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir.md
FIR -- requirements
Module: fir

Interface
REQ-001 The module SHALL have one clock and a reset that is asynchronous and active-high.
REQ-002 The module SHALL have a parameter DATA_W, default 32, which is the input and output sample width.
REQ-003 Ports SHALL be, in this order:
- clk, input, 1 bit: rising-edge clock.
- Reset, input, 1 bit: asynchronous, active-high reset.
- Data_in, input, DATA_W bits: unsigned input sample, taken on every rising edge.
- Data_out, output, DATA_W bits: unsigned filtered sample, driven from a register.

Function
REQ-004 The block SHALL be an 8-tap direct-form FIR filter with fixed unsigned coefficients c[0..7] = 1, 6, 18, 39, 39, 18, 6, 1 (sum = 128, unity DC gain).
REQ-005 The block SHALL have no handshake: one sample enters on every rising clk edge, and there is no valid signal and no stall.
REQ-006 The block SHALL hold a delay line x[1..7] holding the 7 previous Data_in values; x[0] is the current Data_in.
REQ-007 On each rising edge, acc SHALL be the sum over k of c[k]*x[k], computed unsigned in a 40-bit accumulator, which is wide enough that it never overflows.
REQ-008 On the same edge, Data_out SHALL be loaded with acc >> 7, truncated to DATA_W bits; the delay line then shifts so that x[1] <= Data_in and x[k] <= x[k-1].
REQ-009 Latency SHALL be one edge: the contribution of a sample applied before edge n appears in Data_out after edge n, and a single impulse affects 8 consecutive outputs.
REQ-010 Full-scale behaviour: a constant 0xFFFFFFFF input SHALL settle to exactly 0xFFFFFFFF, with no wrap-around.
REQ-011 Between edges, Data_out SHALL be stable and SHALL NOT depend combinationally on Data_in.

Reset
REQ-012 While Reset is high, Data_out and all delay-line registers SHALL be 0, cleared asynchronously without waiting for a clk edge.
REQ-013 Reset asserted mid-stream SHALL discard all history: the first output after release SHALL depend only on samples applied after release.
REQ-014 Edge 1 after Reset deasserts SHALL produce c[0]*Data_in >> 7, since all older taps are zero.

Configuration
REQ-015 The macro FIR_ROUND_EN SHALL select the output scaling.
- When FIR_ROUND_EN is defined, Data_out SHALL be (acc + 64) >> 7, i.e. round-half-up.
- When FIR_ROUND_EN is undefined, Data_out SHALL be acc >> 7, i.e. truncation.
- The 40-bit accumulator SHALL not overflow in either mode.

Structure
REQ-016 A shared package fir_pkg SHALL hold NTAPS = 8, COEF_W = 6, the coefficient array, COEF_SHIFT = 7, ROUND_CONST = 64 and ACC_W = 40.
REQ-017 The delay line SHALL be one sub-module, fir_delay_line, which holds NTAPS-1 registers of DATA_W bits and has an asynchronous reset; the multiply-accumulate and output register SHALL be in the top-level module.

Verification
REQ-018 Impulse test, truncate mode: Data_in = 128 for one cycle, 0 otherwise -> Data_out = 1, 6, 18, 39, 39, 18, 6, 1, then 0.
REQ-019 Step test: constant 1000 from reset release -> outputs ramp as 7, 54, 195, 500, 804, 945, 992, then hold at 1000 from edge 8.
REQ-020 Rounding test: impulse of 100.
- Truncate mode -> 0, 4, 14, 30, 30, 14, 4, 0.
- FIR_ROUND_EN mode -> 1, 5, 14, 30, 30, 14, 5, 1.
REQ-021 Full-scale test: constant 0xFFFFFFFF -> Data_out = 0xFFFFFFFF from edge 8 onward, with no wrap-around.
REQ-022 Reset mid-stream test: run the constant-1000 step, then pulse Reset for 5 ns between edges.
- Data_out SHALL go to 0 immediately.
- After release with input 1000, the output SHALL re-ramp from 7.
REQ-023 Random-stream test: 1000 random 32-bit samples -> every output SHALL match a bit-exact reference model of REQ-007/REQ-008; the mean relative error SHALL be 0.
